sh7604_int_seq: RTL and testbench

SH7604_INT_SEQ -- requirements
Module: sh7604_int_seq

---
 rtl/sh7604_int_seq.sv | 157 +++++++++++++++
 tb/tb_sh7604_int_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sh7604_int_seq.sv
// SH7604 interrupt entry sequencer.
// Accepts an interrupt at an instruction boundary, then fetches the vector
// number from the INTC. It pushes SR and the return PC onto the stack, reads
// the handler address from the vector table, and hands the new PC, SP and
// mask level to the CPU core.
// Optional feature macro: SH7604_INT_SEQ_DSLOT_GUARD_EN. When it is defined,
// acceptance is held off while the current instruction is a delay slot.
module sh7604_int_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        EN,
    input  logic        INT_REQ,
    input  logic [3:0]  INT_LVL,
    input  logic [7:0]  INT_VEC,
    input  logic        NMI_REQ,
    output logic        INT_ACP,
    output logic        INT_ACK,
    output logic        VECT_REQ,
    input  logic        VECT_WAIT,
    input  logic        INST_BND,
    input  logic        DELAY_SLOT,
    input  logic [3:0]  SR_I,
    input  logic [31:0] SR,
    input  logic [31:0] RET_PC,
    input  logic [31:0] SP,
    input  logic [31:0] VBR,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_DO,
    input  logic [31:0] MEM_DI,
    output logic        MEM_WE,
    output logic        MEM_REQ,
    input  logic        MEM_BUSY,
    output logic [31:0] NEW_PC,
    output logic [31:0] NEW_SP,
    output logic [3:0]  NEW_I,
    output logic        UPD,
    output logic        SEQ_BUSY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEPT  = 3'd1,
        VECT    = 3'd2,
        PUSH_SR = 3'd3,
        PUSH_PC = 3'd4,
        RD_VEC  = 3'd5,
        JUMP    = 3'd6
    } seq_state_t;

    seq_state_t state;
    logic [3:0] lvl_l;
    logic [7:0] vec_l;
    logic       step;
    logic       dslot_block;
    logic       take_int;

    assign step = EN && CE_R;

`ifdef SH7604_INT_SEQ_DSLOT_GUARD_EN
    assign dslot_block = DELAY_SLOT;
`else
    logic unused_dslot;
    assign unused_dslot = DELAY_SLOT;
    assign dslot_block  = 1'b0;
`endif

    assign take_int = INT_REQ && INST_BND && !dslot_block &&
                      (NMI_REQ || (INT_LVL > SR_I));

    assign SEQ_BUSY = (state != IDLE);

    // Sequencer: the state, the latches and every registered output advance only on enabled steps, while the pulses clear on each CLK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            lvl_l    <= 4'd0;
            vec_l    <= 8'd0;
            INT_ACP  <= 1'b0;
            INT_ACK  <= 1'b0;
            VECT_REQ <= 1'b0;
            MEM_A    <= 32'd0;
            MEM_DO   <= 32'd0;
            MEM_WE   <= 1'b0;
            MEM_REQ  <= 1'b0;
            NEW_PC   <= 32'd0;
            NEW_SP   <= 32'd0;
            NEW_I    <= 4'd0;
            UPD      <= 1'b0;
        end else begin
            INT_ACP <= 1'b0;
            INT_ACK <= 1'b0;
            UPD     <= 1'b0;
            if (step) begin
                unique case (state)
                    IDLE: begin
                        if (take_int) begin
                            state   <= ACCEPT;
                            INT_ACP <= 1'b1;
                            lvl_l   <= NMI_REQ ? 4'hF : INT_LVL;
                        end
                    end
                    ACCEPT: begin
                        state    <= VECT;
                        VECT_REQ <= 1'b1;
                    end
                    VECT: begin
                        if (VECT_REQ) begin
                            VECT_REQ <= 1'b0;
                        end else if (!VECT_WAIT) begin
                            vec_l   <= INT_VEC;
                            state   <= PUSH_SR;
                            MEM_A   <= SP - 32'd4;
                            MEM_DO  <= SR;
                            MEM_WE  <= 1'b1;
                            MEM_REQ <= 1'b1;
                        end
                    end
                    PUSH_SR: begin
                        if (!MEM_BUSY) begin
                            state  <= PUSH_PC;
                            MEM_A  <= SP - 32'd8;
                            MEM_DO <= RET_PC;
                        end
                    end
                    PUSH_PC: begin
                        if (!MEM_BUSY) begin
                            state  <= RD_VEC;
                            MEM_A  <= VBR + {22'd0, vec_l, 2'b00};
                            MEM_DO <= 32'd0;
                            MEM_WE <= 1'b0;
                        end
                    end
                    RD_VEC: begin
                        if (!MEM_BUSY) begin
                            state   <= JUMP;
                            MEM_REQ <= 1'b0;
                            MEM_A   <= 32'd0;
                            NEW_PC  <= MEM_DI;
                            NEW_SP  <= SP - 32'd8;
                            NEW_I   <= lvl_l;
                            UPD     <= 1'b1;
                            INT_ACK <= 1'b1;
                        end
                    end
                    JUMP: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sh7604_int_seq.sv
// Self-checking bench for sh7604_int_seq.
// The bench plays the INTC and the memory. Each interrupt entry is checked
// against a transaction-level model: the expected stack writes, the expected
// vector read and the final PC, SP and mask.
module tb_sh7604_int_seq;

    logic        CLK = 1'b0;
    logic        RST, CE_R, EN, INT_REQ, NMI_REQ, VECT_WAIT, INST_BND, DELAY_SLOT, MEM_BUSY;
    logic [3:0]  INT_LVL, SR_I;
    logic [7:0]  INT_VEC;
    logic [31:0] SR, RET_PC, SP, VBR, MEM_DI;
    logic        INT_ACP, INT_ACK, VECT_REQ, MEM_WE, MEM_REQ, UPD, SEQ_BUSY;
    logic [31:0] MEM_A, MEM_DO, NEW_PC, NEW_SP;
    logic [3:0]  NEW_I;

    int tests_run = 0;
    int tests_failed = 0;

    sh7604_int_seq dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .EN(EN), .INT_REQ(INT_REQ), .INT_LVL(INT_LVL),
        .INT_VEC(INT_VEC), .NMI_REQ(NMI_REQ), .INT_ACP(INT_ACP), .INT_ACK(INT_ACK),
        .VECT_REQ(VECT_REQ), .VECT_WAIT(VECT_WAIT), .INST_BND(INST_BND), .DELAY_SLOT(DELAY_SLOT),
        .SR_I(SR_I), .SR(SR), .RET_PC(RET_PC), .SP(SP), .VBR(VBR), .MEM_A(MEM_A), .MEM_DO(MEM_DO),
        .MEM_DI(MEM_DI), .MEM_WE(MEM_WE), .MEM_REQ(MEM_REQ), .MEM_BUSY(MEM_BUSY),
        .NEW_PC(NEW_PC), .NEW_SP(NEW_SP), .NEW_I(NEW_I), .UPD(UPD), .SEQ_BUSY(SEQ_BUSY)
    );

    always #5 CLK = ~CLK;

    // Runs one full interrupt entry with the bench acting as INTC and memory.
    // The vector phase waits wait_steps steps and each memory access is busy
    // for busy_steps steps.
    task automatic run_irq(input logic [3:0] sr_i, input logic [3:0] lvl, input logic nmi,
                           input logic [7:0] vec, input logic [31:0] sp, input logic [31:0] vbr,
                           input logic [31:0] sr, input logic [31:0] ret_pc, input logic [31:0] mem_val,
                           input int wait_steps, input int busy_steps, input bit rand_ce,
                           input int dslot_hold, output int first_acp);
        int acp_cnt = 0, ack_cnt = 0, upd_cnt = 0, vreq_steps = 0, vect_err = 0;
        int stab_err = 0, busy_err = 0, n_acc = 0, vphase = 0, vw_left = 0, m_left = 0;
        int drain = -1, cyc = 0;
        bit mpend = 0, seen_acp = 0, done = 0, step;
        logic [31:0] m_a = 0, m_do = 0;
        logic m_we = 0;
        logic [31:0] acc_a[4], acc_d[4];
        logic acc_w[4];
        logic [31:0] got_pc = 0, got_sp = 0, exp_rd;
        logic [3:0] got_i = 0, exp_i;
        for (int k = 0; k < 4; k++) begin acc_a[k] = 0; acc_d[k] = 0; acc_w[k] = 0; end
        first_acp = -1;
        exp_rd = vbr + 32'(vec) * 32'd4;
        exp_i = nmi ? 4'hF : lvl;
        SR_I = sr_i; INT_LVL = lvl; NMI_REQ = nmi; INT_VEC = vec; SP = sp; VBR = vbr;
        SR = sr; RET_PC = ret_pc; INT_REQ = 1'b1; INST_BND = 1'b1;
        DELAY_SLOT = (dslot_hold > 0); EN = 1'b1; CE_R = 1'b1; VECT_WAIT = 1'b0; MEM_BUSY = 1'b0;
        while (!done && cyc < 800) begin
            @(negedge CLK);
            cyc++;
            if (INT_ACP === 1'b1) begin acp_cnt++; if (first_acp < 0) first_acp = cyc; seen_acp = 1; end
            if (INT_ACK === 1'b1) ack_cnt++;
            if (UPD === 1'b1) begin
                upd_cnt++; got_pc = NEW_PC; got_sp = NEW_SP; got_i = NEW_I;
                if (drain < 0) drain = 4;
            end
            if (seen_acp && upd_cnt == 0 && SEQ_BUSY !== 1'b1) busy_err++;
            DELAY_SLOT = (cyc < dslot_hold);
            if (drain >= 0) begin
                EN = 1'b1; CE_R = 1'b1; INT_REQ = 1'b0; NMI_REQ = 1'b0;
                drain--;
                if (drain == 0) done = 1;
            end else begin
                if (rand_ce) begin
                    EN = ($urandom_range(0, 7) != 0);
                    CE_R = ($urandom_range(0, 3) != 0);
                end
                if (seen_acp) begin
                    INT_REQ = 1'($urandom); NMI_REQ = 1'($urandom); INT_LVL = 4'($urandom);
                end
            end
            step = EN && CE_R;
            // Vector fetch handshake
            if (vphase == 2) begin
                if (MEM_REQ !== 1'b1) vect_err++;
                vphase = 3;
            end else if (vphase == 1 && MEM_REQ === 1'b1) begin
                vect_err++;
            end
            VECT_WAIT = 1'($urandom);
            if (VECT_REQ === 1'b1 && step) begin
                vreq_steps++;
                if (vphase == 0) begin vphase = 1; vw_left = wait_steps; end
            end else if (vphase == 1 && step) begin
                if (vw_left > 0) begin VECT_WAIT = 1'b1; vw_left--; end
                else begin VECT_WAIT = 1'b0; vphase = 2; end
            end
            // Memory responder
            if (!mpend && MEM_REQ === 1'b1) begin
                mpend = 1; m_a = MEM_A; m_do = MEM_DO; m_we = MEM_WE; m_left = busy_steps;
            end else if (mpend && (MEM_REQ !== 1'b1 || MEM_A !== m_a || MEM_DO !== m_do || MEM_WE !== m_we)) begin
                stab_err++;
            end
            MEM_BUSY = 1'($urandom);
            MEM_DI = $urandom;
            if (mpend && step) begin
                if (m_left > 0) begin MEM_BUSY = 1'b1; m_left--; end
                else begin
                    MEM_BUSY = 1'b0;
                    if (n_acc < 4) begin acc_a[n_acc] = m_a; acc_d[n_acc] = m_do; acc_w[n_acc] = m_we; end
                    n_acc++;
                    if (!m_we) MEM_DI = mem_val;
                    mpend = 0;
                end
            end
        end
        INT_REQ = 1'b0; NMI_REQ = 1'b0; DELAY_SLOT = 1'b0;
        tests_run++;
        if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL seq_timeout: got done=%0d required 1 after %0d cycles", done, cyc); end
        tests_run++;
        if (acp_cnt !== 1) begin tests_failed++; $display("[TB] FAIL acp_count: got %0d required 1", acp_cnt); end
        tests_run++;
        if (ack_cnt !== 1 || upd_cnt !== 1) begin tests_failed++; $display("[TB] FAIL ack_upd_count: got ack=%0d upd=%0d required 1/1", ack_cnt, upd_cnt); end
        tests_run++;
        if (vreq_steps !== 1 || vect_err !== 0) begin tests_failed++; $display("[TB] FAIL vect_handshake: got req_steps=%0d timing_err=%0d required 1/0", vreq_steps, vect_err); end
        tests_run++;
        if (stab_err !== 0 || busy_err !== 0) begin tests_failed++; $display("[TB] FAIL stability: got mem_unstable=%0d busy_low=%0d required 0/0", stab_err, busy_err); end
        tests_run++;
        if (n_acc !== 3) begin tests_failed++; $display("[TB] FAIL access_count: got %0d required 3", n_acc); end
        tests_run++;
        if (acc_a[0] !== sp - 32'd4 || acc_d[0] !== sr || acc_w[0] !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL push_sr: got a=%h d=%h we=%b required a=%h d=%h we=1", acc_a[0], acc_d[0], acc_w[0], sp - 32'd4, sr);
        end
        tests_run++;
        if (acc_a[1] !== sp - 32'd8 || acc_d[1] !== ret_pc || acc_w[1] !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL push_pc: got a=%h d=%h we=%b required a=%h d=%h we=1", acc_a[1], acc_d[1], acc_w[1], sp - 32'd8, ret_pc);
        end
        tests_run++;
        if (acc_a[2] !== exp_rd || acc_w[2] !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL rd_vec: got a=%h we=%b required a=%h we=0", acc_a[2], acc_w[2], exp_rd);
        end
        tests_run++;
        if (got_pc !== mem_val || got_sp !== sp - 32'd8 || got_i !== exp_i) begin
            tests_failed++; $display("[TB] FAIL new_ctx: got pc=%h sp=%h i=%h required pc=%h sp=%h i=%h", got_pc, got_sp, got_i, mem_val, sp - 32'd8, exp_i);
        end
        tests_run++;
        if (SEQ_BUSY !== 1'b0) begin tests_failed++; $display("[TB] FAIL back_to_idle: got seq_busy=%b required 0", SEQ_BUSY); end
    endtask

    // Reset with EN and CE_R low must still clear everything.
    task automatic test_reset;
        RST = 1'b1; EN = 1'b0; CE_R = 1'b0; INT_REQ = 1'b0; NMI_REQ = 1'b0; INT_LVL = 0; INT_VEC = 0;
        VECT_WAIT = 0; INST_BND = 0; DELAY_SLOT = 0; MEM_BUSY = 0; SR_I = 0; SR = 0; RET_PC = 0;
        SP = 0; VBR = 0; MEM_DI = 0;
        repeat (2) @(negedge CLK);
        tests_run++;
        if ({INT_ACP, INT_ACK, VECT_REQ, MEM_WE, MEM_REQ, UPD, SEQ_BUSY} !== 7'd0) begin
            tests_failed++; $display("[TB] FAIL reset_ctrl: got %b required 0000000", {INT_ACP, INT_ACK, VECT_REQ, MEM_WE, MEM_REQ, UPD, SEQ_BUSY});
        end
        tests_run++;
        if (MEM_A !== 32'd0 || MEM_DO !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_mem: got a=%h d=%h required 0/0", MEM_A, MEM_DO); end
        tests_run++;
        if (NEW_PC !== 32'd0 || NEW_SP !== 32'd0 || NEW_I !== 4'd0) begin
            tests_failed++; $display("[TB] FAIL reset_ctx: got pc=%h sp=%h i=%h required 0/0/0", NEW_PC, NEW_SP, NEW_I);
        end
        RST = 1'b0;
    endtask

    // A valid request must be ignored while EN or CE_R is low.
    task automatic test_gating;
        int acp = 0, busy = 0;
        SR_I = 4'd1; INT_LVL = 4'd6; NMI_REQ = 1'b0; INST_BND = 1'b1; INT_REQ = 1'b1;
        for (int i = 0; i < 8; i++) begin
            EN = (i >= 4); CE_R = (i < 4);
            @(negedge CLK);
            if (INT_ACP === 1'b1) acp++;
            if (SEQ_BUSY !== 1'b0) busy++;
        end
        INT_REQ = 1'b0; EN = 1'b1; CE_R = 1'b1;
        tests_run++;
        if (acp !== 0 || busy !== 0) begin tests_failed++; $display("[TB] FAIL gating: got acp=%0d busy=%0d required 0/0", acp, busy); end
    endtask

    // IRL level 9 over mask 3 with the reference addresses.
    task automatic test_irl9;
        int fa;
        run_irq(4'd3, 4'd9, 1'b0, 8'h44, 32'h0600_1000, 32'h0600_0000, 32'h0000_00F0, 32'h0600_2222,
                32'h0600_4000, 0, 0, 1'b0, 0, fa);
        tests_run++;
        if (fa !== 1) begin tests_failed++; $display("[TB] FAIL irl9_accept_cycle: got %0d required 1", fa); end
    endtask

    // Level equal to mask is blocked; NMI then forces acceptance at level 15.
    task automatic test_nmi;
        int acp = 0, busy = 0, fa;
        logic [3:0] m;
        SR_I = 4'd3; INT_LVL = 4'd3; NMI_REQ = 1'b0; INST_BND = 1'b1; INT_REQ = 1'b1; EN = 1'b1; CE_R = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i >= 10) begin
                m = 4'($urandom); SR_I = m; INT_LVL = 4'($urandom_range(0, int'(m)));
            end
            @(negedge CLK);
            if (INT_ACP === 1'b1) acp++;
            if (SEQ_BUSY !== 1'b0) busy++;
        end
        INT_REQ = 1'b0;
        tests_run++;
        if (acp !== 0 || busy !== 0) begin tests_failed++; $display("[TB] FAIL masked_level: got acp=%0d busy=%0d required 0/0", acp, busy); end
        run_irq(4'd3, 4'd3, 1'b1, 8'h0B, 32'h0600_1000, 32'h0600_0000, 32'h0000_0033, 32'h0600_0100,
                32'h0000_1234, 0, 0, 1'b0, 0, fa);
    endtask

    // Long vector wait and busy memory, with the stack wrapping below zero.
    task automatic test_stalls;
        int fa;
        run_irq(4'd0, 4'd5, 1'b0, 8'h40, 32'h0000_0004, 32'h0000_0400, 32'h0000_00A5, 32'h0000_8888,
                32'h0000_2000, 5, 3, 1'b0, 0, fa);
        run_irq(4'd2, 4'd12, 1'b0, 8'hFF, 32'h0600_3000, 32'hFFFF_FF00, 32'h0000_0001, 32'h0601_0000,
                32'h0000_0500, 5, 3, 1'b1, 0, fa);
    endtask

    // Reset during the PC push aborts cleanly and a fresh entry still works.
    task automatic test_reset_mid;
        int cyc = 0, extra = 0, fa;
        bit hit = 0;
        SR_I = 4'd2; INT_LVL = 4'd7; NMI_REQ = 1'b0; INT_VEC = 8'h21; SP = 32'h0600_2000;
        VBR = 32'h0600_0000; SR = 32'h0000_0020; RET_PC = 32'h0600_0ABC; INT_REQ = 1'b1; INST_BND = 1'b1;
        DELAY_SLOT = 1'b0; EN = 1'b1; CE_R = 1'b1; VECT_WAIT = 1'b0; MEM_BUSY = 1'b0;
        while (!hit && cyc < 60) begin
            @(negedge CLK);
            cyc++;
            if (INT_ACP === 1'b1) INT_REQ = 1'b0;
            if (MEM_REQ === 1'b1 && MEM_A === 32'h0600_1FF8) hit = 1;
        end
        tests_run++;
        if (hit !== 1'b1) begin tests_failed++; $display("[TB] FAIL reach_push_pc: got %b required 1", hit); end
        INT_REQ = 1'b0; MEM_BUSY = 1'b1; RST = 1'b1;
        @(negedge CLK);
        tests_run++;
        if ({MEM_REQ, VECT_REQ, SEQ_BUSY, UPD, INT_ACK} !== 5'd0 || NEW_PC !== 32'd0) begin
            tests_failed++; $display("[TB] FAIL abort: got req/vreq/busy/upd/ack=%b pc=%h required 00000 0", {MEM_REQ, VECT_REQ, SEQ_BUSY, UPD, INT_ACK}, NEW_PC);
        end
        RST = 1'b0; MEM_BUSY = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            if (UPD === 1'b1 || INT_ACK === 1'b1 || INT_ACP === 1'b1) extra++;
        end
        tests_run++;
        if (extra !== 0) begin tests_failed++; $display("[TB] FAIL post_abort_pulses: got %0d required 0", extra); end
        run_irq(4'd2, 4'd7, 1'b0, 8'h21, 32'h0600_2000, 32'h0600_0000, 32'h0000_0020, 32'h0600_0ABC,
                32'h0600_7000, 1, 1, 1'b0, 0, fa);
    endtask

    // Delay-slot guard: blocked until DELAY_SLOT drops when the macro is set, immediate otherwise.
    task automatic test_dslot;
        int fa, exp_fa;
`ifdef SH7604_INT_SEQ_DSLOT_GUARD_EN
        exp_fa = 6;
`else
        exp_fa = 1;
`endif
        run_irq(4'd4, 4'd10, 1'b0, 8'h50, 32'h0600_0800, 32'h0000_0000, 32'h0000_0040, 32'h0000_0100,
                32'h0000_3000, 0, 0, 1'b0, 5, fa);
        tests_run++;
        if (fa !== exp_fa) begin tests_failed++; $display("[TB] FAIL dslot_accept_cycle: got %0d required %0d", fa, exp_fa); end
    endtask

    // Randomised entries with random gating, stalls and context values.
    task automatic test_random;
        int fa;
        logic [3:0] m, l;
        logic n;
        for (int i = 0; i < 6; i++) begin
            n = 1'($urandom);
            m = 4'($urandom_range(0, 14));
            l = n ? 4'($urandom) : 4'($urandom_range(int'(m) + 1, 15));
            run_irq(m, l, n, 8'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 3), 1'b1, 0, fa);
        end
    endtask

    initial begin
        test_reset;
        test_gating;
        test_irl9;
        test_nmi;
        test_stalls;
        test_reset_mid;
        test_dslot;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
